// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   OP_MULTU / OP_DIVU : encodings of the op select input
//   state_t            : controller states (IDLE, RUN, DONE)
package muldiv_seq_pkg;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle of the sequential multiply/divide unit.
//   master : drives start, op, a, b; observes busy, done, hi, lo, div_by_zero
//   slave  : the unit itself
interface muldiv_seq_if #(
    parameter int unsigned WIDE = 32
);

    logic            start;
    logic            op;
    logic [WIDE-1:0] a;
    logic [WIDE-1:0] b;
    logic            busy;
    logic            done;
    logic [WIDE-1:0] hi;
    logic [WIDE-1:0] lo;
    logic            div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );

endinterface

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply (shift-add) and divide (restoring), one bit
// per clock. An operation takes WIDE cycles in RUN followed by one DONE cycle
// in which done pulses; hi/lo/div_by_zero are registered on entry to DONE and
// held until the next completion.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : slave side of muldiv_seq_if (start/op/a/b in; busy/done/hi/lo/div_by_zero out)
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDE = 32
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);

    localparam int unsigned CW = (WIDE > 1) ? $clog2(WIDE) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            op_q;
    logic [WIDE:0]   acc_q;    // product upper half (MULTU) or partial remainder (DIVU)
    logic [WIDE-1:0] q_q;      // multiplier/product-low (MULTU) or dividend/quotient (DIVU)
    logic [WIDE-1:0] opnd_q;   // multiplicand (MULTU) or divisor (DIVU)
    logic            dz_pend_q;
    logic [WIDE-1:0] hi_q, lo_q;
    logic            dz_q;

    logic            accept, last;
    logic [WIDE:0]   add_x, add_y, add_out, mul_s, acc_n;
    logic [WIDE-1:0] q_n;

    // Controller: next state and status outputs
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    last    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: one shared WIDE+1-bit adder/subtractor
    always_comb begin
        add_x   = (op_q == OP_DIVU) ? {acc_q[WIDE-1:0], q_q[WIDE-1]} : acc_q;
        add_y   = {1'b0, opnd_q};
        add_out = (op_q == OP_DIVU) ? (add_x - add_y) : (add_x + add_y);
        mul_s   = q_q[0] ? add_out : acc_q;
        if (op_q == OP_DIVU) begin
            // Shifted remainder is below 2*divisor, so the top bit of the
            // difference is exactly the borrow: set means restore.
            // A zero divisor never borrows, which naturally yields
            // quotient = all ones and remainder = dividend.
            acc_n = add_out[WIDE] ? add_x : add_out;
            q_n   = {q_q[WIDE-2:0], ~add_out[WIDE]};
        end else begin
            acc_n = {1'b0, mul_s[WIDE:1]};
            q_n   = {mul_s[0], q_q[WIDE-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            op_q      <= OP_MULTU;
            acc_q     <= '0;
            q_q       <= '0;
            opnd_q    <= '0;
            dz_pend_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else if (accept) begin
            cnt_q     <= CW'(WIDE - 1);
            op_q      <= bus.op;
            acc_q     <= '0;
            dz_pend_q <= (bus.op == OP_DIVU) && (bus.b == '0);
            if (bus.op == OP_DIVU) begin
                q_q    <= bus.a;
                opnd_q <= bus.b;
            end else begin
                q_q    <= bus.b;
                opnd_q <= bus.a;
            end
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q - CW'(1);
            acc_q <= acc_n;
            q_q   <= q_n;
            if (last) begin
                hi_q <= acc_n[WIDE-1:0];
                lo_q <= q_n;
                dz_q <= dz_pend_q;
            end
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDE = 32): an arithmetic reference
// model predicts every cycle's outputs, and directed operations are pinned
// against hand-computed literal results.
module tb_muldiv_seq;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    muldiv_seq_if #(.WIDE(W)) bus_if ();

    muldiv_seq #(.WIDE(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: an accepted operation occupies W+2 cycles; the result
    // becomes visible W edges after the accepting edge.
    bit          m_active = 1'b0;
    int          m_cyc = 0;
    int          m_t = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    logic        m_dz = 1'b0, m_pdz = 1'b0;

    initial begin
        logic [63:0] prod;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0;
                m_hi = '0;
                m_lo = '0;
                m_dz = 1'b0;
            end else begin
                m_cyc++;
                if (m_active) begin
                    if (m_cyc - m_t == W) begin
                        m_hi = m_phi;
                        m_lo = m_plo;
                        m_dz = m_pdz;
                    end else if (m_cyc - m_t == W + 1) begin
                        m_active = 1'b0;
                    end
                end else if (bus_if.start) begin
                    m_active = 1'b1;
                    m_t = m_cyc;
                    if (bus_if.op == 1'b0) begin
                        prod = 64'(bus_if.a) * 64'(bus_if.b);
                        m_phi = prod[63:32];
                        m_plo = prod[31:0];
                        m_pdz = 1'b0;
                    end else if (bus_if.b == 32'd0) begin
                        m_phi = bus_if.a;
                        m_plo = 32'hFFFF_FFFF;
                        m_pdz = 1'b1;
                    end else begin
                        m_plo = bus_if.a / bus_if.b;
                        m_phi = bus_if.a % bus_if.b;
                        m_pdz = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        logic eb, ed;
        forever begin
            @(negedge clk);
            eb = m_active;
            ed = m_active && (m_cyc - m_t == W);
            if (bus_if.done) done_cnt++;
            tests++;
            if (bus_if.busy !== eb || bus_if.done !== ed || bus_if.hi !== m_hi ||
                bus_if.lo !== m_lo || bus_if.div_by_zero !== m_dz) begin
                fails++;
                $display("FAIL cycle t=%0t busy=%b/%b done=%b/%b hi=%h/%h lo=%h/%h dz=%b/%b (got/exp)",
                         $time, bus_if.busy, eb, bus_if.done, ed, bus_if.hi, m_hi,
                         bus_if.lo, m_lo, bus_if.div_by_zero, m_dz);
            end
        end
    end

    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Called at a negedge: presents the request, scrambles inputs during RUN,
    // optionally pokes a second start mid-run, then waits for done.
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input string nm, input bit poke);
        int n;
        bit seen;
        bus_if.start = 1'b1;
        bus_if.op = o;
        bus_if.a = x;
        bus_if.b = y;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.op = ~o;
        bus_if.a = $urandom;
        bus_if.b = $urandom;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (bus_if.done) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                n++;
                if (poke && n == 5) begin
                    bus_if.start = 1'b1;
                    bus_if.op = 1'b1;
                    bus_if.a = 32'd9;
                    bus_if.b = 32'd3;
                end else if (poke && n == 6) begin
                    bus_if.start = 1'b0;
                end
            end
        end
        check32({nm, "_latency"}, 32'(n), 32'(W));
        check32({nm, "_hi"}, bus_if.hi, eh);
        check32({nm, "_lo"}, bus_if.lo, el);
        check32({nm, "_dz"}, {31'd0, bus_if.div_by_zero}, {31'd0, edz});
    endtask

    initial begin
        int base;
        int dcyc[$];
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op = 1'b0;
        bus_if.a = '0;
        bus_if.b = '0;
        repeat (3) @(negedge clk);
        check32("reset_busy", {31'd0, bus_if.busy}, 32'd0);
        check32("reset_lo", bus_if.lo, 32'd0);
        rst = 1'b0;

        @(negedge clk); run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "mul_max", 1'b0);
        @(negedge clk); run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "div_100_7", 1'b0);
        @(negedge clk); run_op(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, "div_by_0", 1'b0);
        @(negedge clk); run_op(1'b0, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, "mul_zero", 1'b0);
        @(negedge clk); run_op(1'b1, 32'd0, 32'd9, 32'd0, 32'd0, 1'b0, "div_zero_num", 1'b0);
        @(negedge clk); run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, "div_by_1", 1'b0);
        @(negedge clk); run_op(1'b1, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0, "div_small", 1'b0);
        @(negedge clk); run_op(1'b0, 32'h8000_0000, 32'd4, 32'd2, 32'd0, 1'b0, "mul_carry", 1'b0);
        @(negedge clk); run_op(1'b1, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0, "div_16", 1'b0);
        @(negedge clk); run_op(1'b1, 32'h8000_0001, 32'h8000_0000, 32'd1, 32'd1, 1'b0, "div_topbit", 1'b0);
        @(negedge clk); run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, "div_near", 1'b0);

        // Start during RUN is ignored; only one completion follows
        base = done_cnt;
        @(negedge clk); run_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "mul_poke", 1'b1);
        repeat (40) @(negedge clk);
        check32("poke_done_count", 32'(done_cnt - base), 32'd1);

        // Asynchronous reset 10 cycles into RUN
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = 1'b0; bus_if.a = 32'hFFFF_FFFF; bus_if.b = 32'd2;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (10) @(negedge clk);
        base = done_cnt;
        #2 rst = 1'b1;
        #1;
        check32("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check32("rst_done", {31'd0, bus_if.done}, 32'd0);
        check32("rst_hi", bus_if.hi, 32'd0);
        check32("rst_lo", bus_if.lo, 32'd0);
        check32("rst_dz", {31'd0, bus_if.div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check32("rst_no_done", 32'(done_cnt - base), 32'd0);

        // Accept on the very first edge after reset release
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, "mul_after_rst", 1'b0);

        // Start held high: back-to-back operations every W+2 cycles
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.op = 1'b0; bus_if.a = 32'd2; bus_if.b = 32'd3;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus_if.done) begin
                dcyc.push_back(i);
                check32("b2b_lo", bus_if.lo, 32'd6);
            end
        end
        bus_if.start = 1'b0;
        check32("b2b_count_ge3", 32'(dcyc.size() >= 3), 32'd1);
        for (int i = 1; i < dcyc.size(); i++)
            check32("b2b_period", 32'(dcyc[i] - dcyc[i-1]), 32'd34);

        repeat (40) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
